mem_port_arbiter: RTL and testbench

Shares the single-port 32x16 data memory between two requesters. Requester 0 is the host/loader path. Requester 1 is the accumulator sequencer FSM. The block grants the memory port by round-robin, supports locked bursts with a burst cap, drives the memory strobes from the granted requester, and routes read data back to the requester that issued the read. It sits between the requesters and the memory, in place of a direct FSM-to-memory connection.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rd_return_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
// Holds the grant state encoding, requester IDs and the read-return tag layout.
package mem_arb_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 5;

  localparam logic ID_HOST = 1'b0;
  localparam logic ID_ACC  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic arb_state_e grant_state(input logic id);
    return id ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// Fixed-latency shift pipe of read tags; the tag at the output marks the cycle
// in which the memory's read data belongs to the requester named by its id.
module rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push,
  output rd_tag_t pop
);

  rd_tag_t [RD_LAT-1:0] stage_q, stage_d;

  always_comb begin
    // NOTE: give every combinational output a value before any branch or loop,
    // otherwise an unassigned path infers a latch.
    stage_d    = stage_q;
    stage_d[0] = push;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: the tag pipe is cleared on reset so no stale read can surface as a
  // valid pulse afterwards; sequential state is always updated with <=.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign pop = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the host
// loader (requester 0) and the accumulator sequencer (requester 1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  input  logic [DATA_W-1:0] DataOut
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    own_id, own_we, own_lock, oth_req, access, pick;
  rd_tag_t push, pop;

  assign own_id   = (state_q == GRANT1);
  assign access   = (state_q != IDLE) & (own_id ? Req1 : Req0);
  assign own_we   = own_id ? We1 : We0;
  assign own_lock = own_id ? Lock1 : Lock0;
  assign oth_req  = own_id ? Req0 : Req1;

  always_comb begin
    Address     = '0;
    DataIN      = '0;
    WriteEnable = 1'b0;
    ReadEnable  = 1'b0;
    if (access) begin
      Address     = own_id ? Addr1 : Addr0;
      DataIN      = own_id ? WData1 : WData0;
      WriteEnable = own_we;
      ReadEnable  = ~own_we;
    end
  end

  // A tenure continues only on a locked access below the burst cap; on any end
  // the other requester wins if it is waiting, so there is never an idle bubble.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pick    = ptr_q;
    unique case (state_q)
      IDLE: begin
        pick = (Req0 & Req1) ? ptr_q : Req1;
        if (Req0 | Req1) begin
          state_d = grant_state(pick);
          ptr_d   = ~pick;
          cnt_d   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (access & own_lock & (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (oth_req) begin
          state_d = grant_state(~own_id);
          ptr_d   = own_id;
          cnt_d   = '0;
        end else if (access) begin
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= ID_HOST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Gnt0 = (state_q == GRANT0);
  assign Gnt1 = (state_q == GRANT1);

  assign push = '{valid: access & ~own_we, id: own_id};

  rd_return_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk (Clock),
    .rst (Reset),
    .push(push),
    .pop (pop)
  );

  assign RValid0 = pop.valid & (pop.id == ID_HOST);
  assign RValid1 = pop.valid & (pop.id == ID_ACC);
  assign RData0  = DataOut;
  assign RData1  = DataOut;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter: two instances (RD_LAT 1 and 2)
// share stimulus and are compared each cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int MAXB = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  logic [1:0]    req  = '0;
  logic [1:0]    we   = '0;
  logic [1:0]    lock = '0;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic [1:0]    gnt_a, rv_a, gnt_b, rv_b;
  logic [DW-1:0] rd_a [2];
  logic [DW-1:0] rd_b [2];
  logic [AW-1:0] adr_a, adr_b;
  logic          re_a, we_a, re_b, we_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b, dl_b0;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .MAX_BURST(MAXB)) dut_a (
    .Clock(Clock), .Reset(Reset),
    .Req0(req[0]), .Req1(req[1]), .We0(we[0]), .We1(we[1]),
    .Lock0(lock[0]), .Lock1(lock[1]), .Addr0(addr[0]), .Addr1(addr[1]),
    .WData0(wdata[0]), .WData1(wdata[1]),
    .Gnt0(gnt_a[0]), .Gnt1(gnt_a[1]), .RValid0(rv_a[0]), .RValid1(rv_a[1]),
    .RData0(rd_a[0]), .RData1(rd_a[1]),
    .Address(adr_a), .ReadEnable(re_a), .WriteEnable(we_a), .DataIN(din_a),
    .DataOut(dout_a)
  );

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .MAX_BURST(MAXB)) dut_b (
    .Clock(Clock), .Reset(Reset),
    .Req0(req[0]), .Req1(req[1]), .We0(we[0]), .We1(we[1]),
    .Lock0(lock[0]), .Lock1(lock[1]), .Addr0(addr[0]), .Addr1(addr[1]),
    .WData0(wdata[0]), .WData1(wdata[1]),
    .Gnt0(gnt_b[0]), .Gnt1(gnt_b[1]), .RValid0(rv_b[0]), .RValid1(rv_b[1]),
    .RData0(rd_b[0]), .RData1(rd_b[1]),
    .Address(adr_b), .ReadEnable(re_b), .WriteEnable(we_b), .DataIN(din_b),
    .DataOut(dout_b)
  );

  // Memory environment: writes come from instance a; each instance has its own
  // read-latency delay line.
  logic [DW-1:0] mem_env [32];
  always @(posedge Clock) begin
    if (we_a) mem_env[adr_a] <= din_a;
    if (re_a) dout_a <= mem_env[adr_a];
    if (re_b) dl_b0 <= mem_env[adr_b];
    dout_b <= dl_b0;
  end

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [DW-1:0] mem_ref [32];
  int            owner  = -1;
  int            ptr    = 0;
  int            burst  = 0;
  ret_t          q_a [$];
  ret_t          q_b [$];
  bit            accepted [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int cur_acc();
    if (Reset || owner < 0) return -1;
    return req[owner] ? owner : -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    ptr   = 0;
    burst = 0;
    q_a.delete();
    q_b.delete();
    accepted[0] = 1'b0;
    accepted[1] = 1'b0;
  endtask

  task automatic check_outputs();
    int            a;
    logic          e_we, e_re, e_rv;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_din;
    a     = cur_acc();
    e_we  = 1'b0;
    e_re  = 1'b0;
    e_adr = '0;
    e_din = '0;
    if (a >= 0) begin
      e_we  = we[a];
      e_re  = ~we[a];
      e_adr = addr[a];
      e_din = wdata[a];
    end
    for (int n = 0; n < 2; n++) begin
      check($sformatf("gnt%0d_a", n), 32'(gnt_a[n]), 32'(owner == n));
      check($sformatf("gnt%0d_b", n), 32'(gnt_b[n]), 32'(owner == n));
      e_rv = (q_a.size() > 0 && q_a[0].due == cyc && q_a[0].id == n);
      check($sformatf("rvalid%0d_a", n), 32'(rv_a[n]), 32'(e_rv));
      if (e_rv) check($sformatf("rdata%0d_a", n), 32'(rd_a[n]), 32'(q_a[0].data));
      e_rv = (q_b.size() > 0 && q_b[0].due == cyc && q_b[0].id == n);
      check($sformatf("rvalid%0d_b", n), 32'(rv_b[n]), 32'(e_rv));
      if (e_rv) check($sformatf("rdata%0d_b", n), 32'(rd_b[n]), 32'(q_b[0].data));
    end
    check("we_a", 32'(we_a), 32'(e_we));
    check("re_a", 32'(re_a), 32'(e_re));
    check("addr_a", 32'(adr_a), 32'(e_adr));
    check("din_a", 32'(din_a), 32'(e_din));
    check("we_b", 32'(we_b), 32'(e_we));
    check("re_b", 32'(re_b), 32'(e_re));
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_advance();
    int a, n, nxt;
    cyc++;
    if (Reset) begin
      model_reset();
      return;
    end
    accepted[0] = 1'b0;
    accepted[1] = 1'b0;
    while (q_a.size() > 0 && q_a[0].due < cyc) void'(q_a.pop_front());
    while (q_b.size() > 0 && q_b[0].due < cyc) void'(q_b.pop_front());
    a = cur_acc();
    if (a >= 0) begin
      accepted[a] = 1'b1;
      if (we[a]) begin
        mem_ref[addr[a]] = wdata[a];
      end else begin
        q_a.push_back('{due: cyc, id: a, data: mem_ref[addr[a]]});
        q_b.push_back('{due: cyc + 1, id: a, data: mem_ref[addr[a]]});
      end
    end
    if (owner < 0) begin
      if (req[0] && req[1]) nxt = ptr;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
      if (nxt >= 0) begin
        owner = nxt;
        ptr   = 1 - nxt;
        burst = 0;
      end
    end else begin
      n = owner;
      if (a >= 0 && lock[n] && burst + 1 < MAXB) begin
        burst++;
      end else if (req[1-n]) begin
        owner = 1 - n;
        ptr   = n;
        burst = 0;
      end else if (req[n]) begin
        burst = 0;
      end else begin
        owner = -1;
      end
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    @(negedge Clock);
    check_outputs();
    model_advance();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input int n, input bit r, input bit w, input bit l,
                       input int a, input int d);
    req[n]   = r;
    we[n]    = w;
    lock[n]  = l;
    addr[n]  = AW'(a);
    wdata[n] = DW'(d);
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'(0));
    check("rst_gnt_b", 32'(gnt_b), 32'(0));
    check("rst_rv_b", 32'(rv_b), 32'(0));
    check("rst_strobe_b", 32'({re_b, we_b}), 32'(0));
    model_reset();
    cycle();
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #1;
    @(posedge Clock);
    #1;
    do_reset();
    cycle();

    // Preload every word through the host port with locked bursts.
    for (int i = 0; i < 32; i++) begin
      int tries;
      drive(0, 1, 1, 1, i, (i == 3) ? 16'h00A5 : ((i * 16'h0421) ^ 16'h5A5A));
      tries = 0;
      do begin
        cycle();
        tries++;
      end while (!accepted[0] && tries < 6);
    end
    idle_inputs();
    cycle();

    // Single read by the accumulator sequencer.
    do_reset();
    drive(1, 1, 0, 0, 3, 0);
    cycle();
    check("t1_gnt1", 32'(gnt_a[1]), 32'(1));
    check("t1_re", 32'(re_a), 32'(1));
    check("t1_addr", 32'(adr_a), 32'(3));
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check("t1_rv1", 32'(rv_a[1]), 32'(1));
    check("t1_rdata", 32'(rd_a[1]), 32'(16'h00A5));
    check("t1_rv0", 32'(rv_a[0]), 32'(0));
    cycle();
    cycle();

    // Strict alternation with both requesting unlocked.
    do_reset();
    drive(0, 1, 0, 0, 7, 0);
    drive(1, 1, 0, 0, 8, 0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t2_alt_c%0d", k), 32'(gnt_a), (k % 2 == 1) ? 32'(2'b01) : 32'(2'b10));
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();

    // Locked burst hits the cap, then the waiting requester gets the port.
    do_reset();
    drive(0, 1, 0, 1, 9, 0);
    drive(1, 1, 0, 0, 10, 0);
    cycle();
    for (int k = 1; k <= MAXB; k++) begin
      check($sformatf("t3_burst_c%0d", k), 32'({gnt_a, re_a}), 32'(3'b011));
      cycle();
    end
    check("t3_handover", 32'(gnt_a), 32'(2'b10));
    idle_inputs();
    repeat (3) cycle();

    // Write 0xFFFF to word 31 from host, read it back from the sequencer.
    do_reset();
    drive(0, 1, 1, 0, 31, 16'hFFFF);
    cycle();
    check("t4_we", 32'(we_a), 32'(1));
    check("t4_din", 32'(din_a), 32'(16'hFFFF));
    check("t4_waddr", 32'(adr_a), 32'(31));
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 31, 0);
    cycle();
    check("t4_rd_issue", 32'({gnt_a[1], re_a}), 32'(2'b11));
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    check("t4_rv_a", 32'(rv_a[1]), 32'(1));
    check("t4_rdata_a", 32'(rd_a[1]), 32'(16'hFFFF));
    cycle();
    check("t4_rv_b", 32'(rv_b[1]), 32'(1));
    check("t4_rdata_b", 32'(rd_b[1]), 32'(16'hFFFF));
    cycle();

    // Reset one cycle after a read issue drops grant and strobes and kills the read.
    do_reset();
    drive(1, 1, 0, 0, 5, 0);
    cycle();
    cycle();
    Reset = 1'b1;
    #1;
    check("t5_gnt_b", 32'(gnt_b), 32'(0));
    check("t5_strobe_b", 32'({re_b, we_b}), 32'(0));
    model_reset();
    cycle();
    Reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_no_rv_b%0d", k), 32'(rv_b), 32'(0));
      cycle();
    end

    // Request withdrawn as its grant appears: no strobe, then handover or idle.
    do_reset();
    drive(0, 1, 0, 0, 4, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 6, 0);
    #1;
    check("t6_gnt0", 32'(gnt_a[0]), 32'(1));
    check("t6_no_strobe", 32'({re_a, we_a}), 32'(0));
    cycle();
    check("t6_to_gnt1", 32'(gnt_a), 32'(2'b10));
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 1, 1, 0, 2, 16'h1234);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("t6b_gnt0", 32'(gnt_a[0]), 32'(1));
    check("t6b_no_strobe", 32'({re_a, we_a}), 32'(0));
    cycle();
    check("t6b_idle", 32'(gnt_a), 32'(0));
    cycle();

    // Randomized traffic with occasional resets and early request withdrawal.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (!req[n] || accepted[n]) begin
            drive(n, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 16'hFFFF)));
          end else if ($urandom_range(0, 15) == 0) begin
            req[n] = 1'b0;
          end
        end
        cycle();
      end
    end
    idle_inputs();
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
